// File: rtl/arithmetic_core_v2.sv
// arithmetic_core_v2
// Streaming convolution arithmetic unit. One beat carries an N_CELL-wide
// activation/weight window plus a bias. The pipeline is:
//   S1 products -> S2 accumulate + bias -> S3 round/saturate/ReLU -> S4 pool/out
// A valid/ready handshake lets the output apply backpressure. While stalled,
// the whole pipeline freezes.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in         packed signed activations, element k = in[k*CELL_BIT +: CELL_BIT]
//   weight     packed signed weights, same packing as in
//   bias       signed bias for this beat
//   shift      requant arithmetic right shift (0..15), rounds half toward +inf
//   en_relu    clamp negative results to zero
//   mp_len     pool window: 0 bypass, 1..3 -> window of 2..4 results
//   in_valid   beat present on the inputs
//   in_ready   core accepts a beat this cycle
//   out        signed result
//   out_valid  out holds a result
//   out_ready  downstream accepts out this cycle
module arithmetic_core_v2 #(
  parameter  int CELL_BIT = 8,
  parameter  int N_CELL   = 9,
  parameter  int BIAS_BIT = 16,
  parameter  int OUT_BIT  = 8,
  localparam int ACC_W    = 2*CELL_BIT + $clog2(N_CELL) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [CELL_BIT*N_CELL-1:0] in,
  input  logic [CELL_BIT*N_CELL-1:0] weight,
  input  logic [BIAS_BIT-1:0]        bias,
  input  logic [3:0]                 shift,
  input  logic                       en_relu,
  input  logic [1:0]                 mp_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [OUT_BIT-1:0]         out,
  output logic                       out_valid,
  input  logic                       out_ready
);

  // Saturation bounds in the widened requant domain.
  localparam logic signed [ACC_W:0] SAT_HI =
    {{(ACC_W-OUT_BIT+2){1'b0}}, {(OUT_BIT-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_LO = ~SAT_HI;

  logic stall;

  always_comb begin
    stall    = out_valid && !out_ready;
    in_ready = !stall;
  end

  // ---------------- S1: element products ----------------
  logic                         s1_valid;
  logic signed [2*CELL_BIT-1:0] s1_prod [N_CELL];
  logic signed [BIAS_BIT-1:0]   s1_bias;
  logic [3:0]                   s1_shift;
  logic                         s1_relu;
  logic [1:0]                   s1_mp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      for (int unsigned k = 0; k < N_CELL; k++) s1_prod[k] <= '0;
      s1_bias  <= '0;
      s1_shift <= '0;
      s1_relu  <= 1'b0;
      s1_mp    <= '0;
    end else if (!stall) begin
      // in_ready is 1 whenever not stalled, so every valid beat is accepted.
      s1_valid <= in_valid;
      for (int unsigned k = 0; k < N_CELL; k++)
        s1_prod[k] <= $signed(in[k*CELL_BIT +: CELL_BIT]) *
                      $signed(weight[k*CELL_BIT +: CELL_BIT]);
      s1_bias  <= $signed(bias);
      s1_shift <= shift;
      s1_relu  <= en_relu;
      s1_mp    <= mp_len;
    end
  end

  // ---------------- S2: accumulate with bias ----------------
  logic signed [ACC_W-1:0] sum;

  always_comb begin
    sum = {{(ACC_W-BIAS_BIT){s1_bias[BIAS_BIT-1]}}, s1_bias};
    for (int unsigned k = 0; k < N_CELL; k++)
      sum = sum + {{(ACC_W-2*CELL_BIT){s1_prod[k][2*CELL_BIT-1]}}, s1_prod[k]};
  end

  logic                    s2_valid;
  logic signed [ACC_W-1:0] s2_acc;
  logic [3:0]              s2_shift;
  logic                    s2_relu;
  logic [1:0]              s2_mp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_acc   <= '0;
      s2_shift <= '0;
      s2_relu  <= 1'b0;
      s2_mp    <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      s2_acc   <= sum;
      s2_shift <= s1_shift;
      s2_relu  <= s1_relu;
      s2_mp    <= s1_mp;
    end
  end

  // ---------------- S3: round, saturate, ReLU ----------------
  // One extra bit of headroom keeps the rounding offset from wrapping.
  logic signed [ACC_W:0]     rq_sum;
  logic signed [ACC_W:0]     rq_shr;
  logic signed [OUT_BIT-1:0] rq_out;

  always_comb begin
    rq_sum = {s2_acc[ACC_W-1], s2_acc};
    if (s2_shift != 4'd0)
      rq_sum = rq_sum + ((ACC_W+1)'(1) << (s2_shift - 4'd1));
    rq_shr = rq_sum >>> s2_shift;
    if (rq_shr > SAT_HI)
      rq_out = SAT_HI[OUT_BIT-1:0];
    else if (rq_shr < SAT_LO)
      rq_out = SAT_LO[OUT_BIT-1:0];
    else
      rq_out = rq_shr[OUT_BIT-1:0];
    if (s2_relu && rq_out[OUT_BIT-1])
      rq_out = '0;
  end

  logic                      s3_valid;
  logic signed [OUT_BIT-1:0] s3_r;
  logic [1:0]                s3_mp;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s3_valid <= 1'b0;
      s3_r     <= '0;
      s3_mp    <= '0;
    end else if (!stall) begin
      s3_valid <= s2_valid;
      s3_r     <= rq_out;
      s3_mp    <= s2_mp;
    end
  end

  // ---------------- S4: pooling and output register ----------------
  // win_len is latched at the first element, so mp_len changes on later
  // beats of the same window do not affect it.
  logic [1:0]                cnt;
  logic [1:0]                win_len;
  logic signed [OUT_BIT-1:0] m;
  logic signed [OUT_BIT-1:0] pool_max;

  always_comb pool_max = (s3_r > m) ? s3_r : m;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out       <= '0;
      out_valid <= 1'b0;
      cnt       <= '0;
      win_len   <= '0;
      m         <= '0;
    end else if (!stall) begin
      // Not stalled means out is empty or being taken this cycle.
      out_valid <= 1'b0;
      if (s3_valid) begin
        if (cnt == 2'd0) begin
          if (s3_mp == 2'd0) begin
            out       <= s3_r;
            out_valid <= 1'b1;
          end else begin
            win_len <= s3_mp;
            m       <= s3_r;
            cnt     <= 2'd1;
          end
        end else if (cnt == win_len) begin
          out       <= pool_max;
          out_valid <= 1'b1;
          cnt       <= 2'd0;
        end else begin
          m   <= pool_max;
          cnt <= cnt + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_arithmetic_core_v2.sv
// Self-checking bench for arithmetic_core_v2: directed test-plan steps followed
// by randomized traffic, all checked against a queue-based reference model.
module tb_arithmetic_core_v2;

  localparam int CB = 8;
  localparam int NC = 9;
  localparam int BB = 16;
  localparam int OB = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [CB*NC-1:0] in;
  logic [CB*NC-1:0] weight;
  logic [BB-1:0]  bias;
  logic [3:0]     shift;
  logic           en_relu;
  logic [1:0]     mp_len;
  logic           in_valid;
  logic           in_ready;
  logic [OB-1:0]  out;
  logic           out_valid;
  logic           out_ready;

  arithmetic_core_v2 #(
    .CELL_BIT(CB),
    .N_CELL  (NC),
    .BIAS_BIT(BB),
    .OUT_BIT (OB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .weight   (weight),
    .bias     (bias),
    .shift    (shift),
    .en_relu  (en_relu),
    .mp_len   (mp_len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out      (out),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Current beat contents
  int a_in [NC];
  int a_w  [NC];
  int b_bias, b_shift, b_relu, b_mp;

  // Reference model state
  logic signed [OB-1:0] expq [$];
  int win [$];
  int win_len;

  function automatic int requant(longint acc, int sh, int relu);
    longint r, d;
    longint hi, lo;
    hi = (longint'(1) << (OB-1)) - 1;
    lo = -(longint'(1) << (OB-1));
    if (sh == 0) r = acc;
    else begin
      d = longint'(1) << sh;
      r = acc + d/2;
      if (r >= 0) r = r / d;
      else        r = -((-r + d - 1) / d);   // floor division
    end
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    if (relu != 0 && r < 0) r = 0;
    return int'(r);
  endfunction

  task automatic model_accept();
    longint acc;
    int r, mx;
    acc = b_bias;
    for (int k = 0; k < NC; k++) acc += longint'(a_in[k]) * longint'(a_w[k]);
    r = requant(acc, b_shift, b_relu);
    if (win.size() == 0) win_len = b_mp + 1;
    win.push_back(r);
    if (win.size() == win_len) begin
      mx = win[0];
      foreach (win[i]) if (win[i] > mx) mx = win[i];
      expq.push_back(OB'(mx));
      win.delete();
    end
  endtask

  task automatic clear_beat();
    for (int k = 0; k < NC; k++) begin a_in[k] = 0; a_w[k] = 0; end
    b_bias = 0; b_shift = 0; b_relu = 0; b_mp = 0;
  endtask

  task automatic set_one(int v, int mp, int sh, int relu, int bs);
    clear_beat();
    a_in[0] = v; a_w[0] = 1;
    b_mp = mp; b_shift = sh; b_relu = relu; b_bias = bs;
  endtask

  // One clock cycle: drive, check handshake outputs mid-cycle, advance.
  task automatic cycle(input logic v, input logic ordy, output logic accepted);
    for (int k = 0; k < NC; k++) begin
      in[k*CB +: CB]     = CB'(a_in[k]);
      weight[k*CB +: CB] = CB'(a_w[k]);
    end
    bias      = BB'(b_bias);
    shift     = 4'(b_shift);
    en_relu   = (b_relu != 0);
    mp_len    = 2'(b_mp);
    in_valid  = v;
    out_ready = ordy;
    #2;
    checks++;
    assert (in_ready === !(out_valid && !out_ready)) else begin
      errors++;
      $error("FAIL in_ready: got %b want %b", in_ready, !(out_valid && !out_ready));
    end
    if (out_valid === 1'b1 && out_ready) begin
      checks++;
      assert (expq.size() > 0) else begin
        errors++;
        $error("FAIL spurious_out: got %0d want no output", $signed(out));
      end
      if (expq.size() > 0) begin
        checks++;
        assert (out === expq[0]) else begin
          errors++;
          $error("FAIL out_value: got %0d want %0d", $signed(out), expq[0]);
        end
        void'(expq.pop_front());
      end
    end
    accepted = in_valid && (in_ready === 1'b1);
    if (accepted) model_accept();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    logic a;
    cycle(1'b0, 1'b1, a);
  endtask

  task automatic beat();
    logic a;
    cycle(1'b1, 1'b1, a);
  endtask

  // Called right after the accept cycle of the last beat that produces a result.
  task automatic check_latency(int val, string tag);
    for (int k = 0; k < 3; k++) begin
      checks++;
      assert (out_valid === 1'b0) else begin
        errors++;
        $error("FAIL %s_early: got out_valid=%b want 0 at +%0d", tag, out_valid, k+1);
      end
      idle();
    end
    checks++;
    assert (out_valid === 1'b1 && out === OB'(val)) else begin
      errors++;
      $error("FAIL %s: got valid=%b out=%0d want valid=1 out=%0d", tag, out_valid, $signed(out), val);
    end
  endtask

  task automatic expect_next(int val, string tag);
    for (int k = 0; k < 12 && out_valid !== 1'b1; k++) idle();
    checks++;
    assert (out_valid === 1'b1 && out === OB'(val)) else begin
      errors++;
      $error("FAIL %s: got valid=%b out=%0d want valid=1 out=%0d", tag, out_valid, $signed(out), val);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && expq.size() > 0; k++) idle();
    checks++;
    assert (expq.size() == 0) else begin
      errors++;
      $error("FAIL drain: got %0d pending results want 0", expq.size());
    end
  endtask

  task automatic check_reset_state(string tag);
    checks++;
    assert (out === '0 && out_valid === 1'b0 && in_ready === 1'b1) else begin
      errors++;
      $error("FAIL %s: got out=%0d valid=%b ready=%b want 0/0/1", tag, $signed(out), out_valid, in_ready);
    end
  endtask

  initial begin
    logic acc_f;
    logic pend;
    int   idx;

    clear_beat();
    in = '0; weight = '0; bias = '0; shift = '0; en_relu = 1'b0; mp_len = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    reset = 1'b1;
    #2 reset = 1'b0;
    #8;
    check_reset_state("reset_state");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_state("after_release");

    // Bypass: 9 * (1*2) + 5 = 23, four cycles after accept
    clear_beat();
    for (int k = 0; k < NC; k++) begin a_in[k] = 1; a_w[k] = 2; end
    b_bias = 5;
    beat();
    clear_beat();
    check_latency(23, "bypass");

    // Saturation, then the same with ReLU
    for (int relu = 0; relu < 2; relu++) begin
      clear_beat();
      for (int k = 0; k < NC; k++) begin a_in[k] = 127; a_w[k] = 127; end
      b_relu = relu;
      beat();
      expect_next(127, "sat_pos");
      for (int k = 0; k < NC; k++) a_w[k] = -128;
      beat();
      expect_next((relu != 0) ? 0 : -128, (relu != 0) ? "relu_neg" : "sat_neg");
    end

    // Rounding half toward +inf
    set_one(3, 0, 1, 0, 0);    beat(); expect_next(2, "round_pos");
    set_one(-3, 0, 1, 0, 0);   beat(); expect_next(-1, "round_neg");
    set_one(0, 0, 4, 0, 100);  beat(); expect_next(6, "round_bias");

    // Pool of 4: 5, -7, 9, 2 -> 9
    set_one(5, 3, 0, 0, 0);  beat();
    set_one(-7, 3, 0, 0, 0); beat();
    set_one(9, 3, 0, 0, 0);  beat();
    set_one(2, 3, 0, 0, 0);  beat();
    check_latency(9, "pool4");

    // Pool of 2: 4, 6 -> 6
    set_one(4, 1, 0, 0, 0); beat();
    set_one(6, 1, 0, 0, 0); beat();
    check_latency(6, "pool2");

    // mp_len dropped to bypass mid-window is ignored until the window ends
    set_one(1, 3, 0, 0, 0); beat();
    set_one(2, 3, 0, 0, 0); beat();
    set_one(3, 0, 0, 0, 0); beat();
    set_one(4, 0, 0, 0, 0); beat();
    check_latency(4, "mp_switch");
    set_one(7, 0, 0, 0, 0); beat();
    expect_next(7, "bypass_resume");

    // Reset in the middle of a window discards it
    idle(); idle();
    set_one(50, 3, 0, 0, 0); beat();
    set_one(60, 3, 0, 0, 0); beat();
    reset = 1'b0;
    #1;
    check_reset_state("midwin_reset");
    expq.delete();
    win.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      set_one(v, 3, 0, 0, 0);
      beat();
    end
    check_latency(4, "after_reset_pool");

    // Backpressure: continuous bypass beats, out_ready low for 3 cycles
    idx = 0;
    for (int c = 0; c < 40 && idx < 10; c++) begin
      set_one(10 + idx, 0, 0, 0, 0);
      cycle(1'b1, !(c >= 6 && c <= 8), acc_f);
      if (acc_f) idx++;
    end
    checks++;
    assert (idx == 10) else begin
      errors++;
      $error("FAIL bp_accept: got %0d accepted want 10", idx);
    end
    drain();

    // Randomized traffic with random backpressure and mid-window mp_len changes
    pend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic v;
      if (!pend) begin
        for (int k = 0; k < NC; k++) begin
          a_in[k] = int'($urandom_range(0, 255)) - 128;
          a_w[k]  = int'($urandom_range(0, 255)) - 128;
        end
        b_bias  = int'($urandom_range(0, 65535)) - 32768;
        b_shift = int'($urandom_range(0, 15));
        b_relu  = int'($urandom_range(0, 1));
        b_mp    = int'($urandom_range(0, 3));
      end
      v = ($urandom_range(0, 3) != 0);
      cycle(v, ($urandom_range(0, 9) < 7), acc_f);
      pend = v && !acc_f;
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arithmetic_core_v2.md
# arithmetic_core_v2

Parametrised successor to the single-kernel arithmetic core. It is a streaming convolution arithmetic unit: an N_CELL-wide signed multiply-accumulate with bias, rounding requantisation with saturation, optional ReLU, and optional 1-D max-pooling over 2–4 consecutive results. It sits between the input/weight buffer fetch logic and the output write-back buffer. It adds a valid/ready handshake with backpressure, a configurable requant shift and a configurable pooling window.

## Interface
- CELL_BIT, 8, width of one input/weight element (signed two's complement)
- N_CELL, 9, elements per kernel window
- BIAS_BIT, 16, bias width (signed)
- OUT_BIT, 8, output width (signed)
- ACC_W, 2*CELL_BIT+$clog2(N_CELL)+1, accumulator width (derived, not overridden)

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in  input  CELL_BIT*N_CELL  packed activations; element k = in[k*CELL_BIT +: CELL_BIT]
- weight  input  CELL_BIT*N_CELL  packed weights, same packing
- bias  input  BIAS_BIT  signed bias for this beat
- shift  input  4  requant arithmetic right shift amount (0–15)
- en_relu  input  1  clamp negative results to 0
- mp_len  input  2  pool window: 0 = bypass, 1 = 2, 2 = 3, 3 = 4 elements
- in_valid  input  1  beat present on in/weight/bias/config
- in_ready  output  1  core accepts beat this cycle
- out  output  OUT_BIT  signed result
- out_valid  output  1  out holds a result
- out_ready  input  1  downstream accepts out this cycle

## Operation
- A beat is accepted when in_valid && in_ready. shift, en_relu and mp_len travel down the pipeline with the beat.
- S1: N_CELL signed products of 2*CELL_BIT bits, registered.
- S2: sum of products plus sign-extended bias, in ACC_W bits. No overflow is possible by construction.
- S3, requant:
  - If shift>0: r = (acc + (1<<(shift-1))) >>> shift. If shift=0: r = acc.
  - Saturate r to [-2^(OUT_BIT-1), 2^(OUT_BIT-1)-1].
  - If en_relu and r<0, r = 0.
- S4, pool/output register:
  - Bypass (mp_len=0): each S3 result is loaded into out with out_valid=1.
  - Pool: a window counter cnt (0..3) and a running max m.
  - First element of a window (cnt=0): latch the window's mp_len as win_len, set m = r.
  - Later elements: m = max(m, r) (signed compare).
  - When cnt reaches win_len, load out = max(m, r), set out_valid=1, clear cnt.
  - An mp_len change inside a window is ignored until that window completes.
- Backpressure:
  - stall = out_valid && !out_ready.
  - in_ready = !stall (combinational).
  - During stall, all stage registers, valid bits, cnt and m hold.
  - out_valid clears on out_ready unless a new result loads in the same cycle.
- Pipeline bubbles (no valid beat) pass through without touching cnt or m.

## Timing
- Reset (asynchronous, reset=0): out=0, out_valid=0, all stage valid bits 0, cnt=0, m=0. in_ready=1 while reset is asserted.
- Reset asserted mid-window discards the partial window and in-flight beats. The first beat after release starts a new window.
- Latency, bypass: beat accepted at cycle t gives out_valid=1 from cycle t+4.
- Latency, pool: out_valid rises at t_last+4, where t_last is the accept cycle of the window's last beat.
- Throughput: one beat per cycle with no stalls. Bypass sustains one result per cycle when out_ready=1.
- Simultaneous out_ready and new result in one cycle: out updates and out_valid stays 1 with no gap.
- Saturation boundaries: acc ≥ 2^(OUT_BIT-1) gives +127; acc < -128 gives -128 (OUT_BIT=8). These are applied before ReLU.
- Rounding is half toward +∞: shift=1, acc=-3 gives -1; acc=3 gives 2.

## Test plan
- Reset and bypass:
  - Stimulus: all in=1, all weight=2, bias=5, shift=0, mp_len=0, one beat at t.
  - Required: out=23, out_valid=1 at t+4. Before the beat: out=0, out_valid=0.
- Saturation and ReLU:
  - Stimulus: in=127, weight=127, bias=0, shift=0 → out=127. in=127, weight=-128 → out=-128. Repeat with en_relu=1.
  - Required: out=0 for the negative case with en_relu=1.
- Rounding:
  - Stimulus: one element 3×1, the rest 0, bias=0, shift=1 → out=2. Element -3×1 → out=-1. bias=100, shift=4 → out=6.
- Pooling:
  - Stimulus: mp_len=3, four beats giving 5, -7, 9, 2.
  - Required: one out=9, four cycles after the 4th beat. Then mp_len=1 with results 4, 6 gives out=6.
  - Also: mp_len switched to 0 after the 2nd beat of a 4-window gives no early output; the window completes at 4 elements.
- Backpressure:
  - Stimulus: continuous beats in bypass, out_ready=0 for 3 cycles.
  - Required: in_ready=0 while out_valid && !out_ready. No result lost or duplicated; sequence order preserved.
- Reset mid-window:
  - Stimulus: assert reset after 2 of 4 pooled beats; release; send 4 beats giving 1, 2, 3, 4.
  - Required: a single out=4. No output from the aborted window.
